// File: rtl/countdown_clock_pkg.sv
// Shared game definitions for the countdown timer: FSM states, time-width
// constants and the difficulty-to-budget lookup.
package countdown_clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  localparam int SEC_PER_MIN = 60;
  localparam int REM_W       = 11;

  // Budget in seconds for a difficulty; difficulties 2 and 3 share the hard budget.
  function automatic logic [REM_W-1:0] limit_for(
    input logic [1:0]       difficulty,
    input logic [REM_W-1:0] lim_easy,
    input logic [REM_W-1:0] lim_med,
    input logic [REM_W-1:0] lim_hard
  );
    logic [REM_W-1:0] lim_s;
    case (difficulty)
      2'd0:    lim_s = lim_easy;
      2'd1:    lim_s = lim_med;
      2'd2:    lim_s = lim_hard;
      default: lim_s = lim_hard;
    endcase
    return lim_s;
  endfunction

endpackage

// File: rtl/countdown_clock_sec_to_min_sec.sv
// Combinational split of an 11-bit seconds count into minutes and seconds.
// Reused by the display path for the stopwatch value as well.
module sec_to_min_sec
  import countdown_clock_pkg::*;
(
  input  logic [REM_W-1:0] total_i,
  output logic [4:0]       minutes_o,
  output logic [5:0]       seconds_o
);

  // Constant division by 60; inputs up to 1919 keep minutes within 5 bits.
  always_comb begin
    minutes_o = 5'(total_i / 11'(SEC_PER_MIN));
    seconds_o = 6'(total_i % 11'(SEC_PER_MIN));
  end

endmodule

// File: rtl/countdown_clock.sv
// Per-game countdown timer. Loads a difficulty-dependent budget on a start
// edge, counts down once per tick while playing, charges a penalty for each
// new mistake and flags warning/expiry. All outputs are registered and are
// derived from the next-state value so they always agree with each other.
module countdown_clock
  import countdown_clock_pkg::*;
#(
  parameter int LIMIT_EASY_S = 900,
  parameter int LIMIT_MED_S  = 600,
  parameter int LIMIT_HARD_S = 300,
  parameter int PENALTY_S    = 30,
  parameter int WARN_S       = 60
) (
  input  logic        clk_1Hz,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  difficulty,
  input  logic        playing_condition,
  input  logic [3:0]  mistakes,
  output logic [10:0] remaining,
  output logic [4:0]  minutes,
  output logic [5:0]  seconds,
  output logic        warning,
  output logic        expired
);

  state_e           state_q, state_d;
  logic             start_q;
  logic [3:0]       mistakes_q, mistakes_d;
  logic [REM_W-1:0] remaining_q, remaining_d;
  logic [4:0]       minutes_q, minutes_d;
  logic [5:0]       seconds_q, seconds_d;
  logic             warning_q, warning_d;
  logic             expired_q, expired_d;
  logic             start_edge_s;
  logic [12:0]      delta_s;
  logic [12:0]      dec_s;

  assign start_edge_s = start & ~start_q;

  // Next-state logic: start edge first, then per-state countdown behaviour.
  always_comb begin
    state_d     = state_q;
    mistakes_d  = mistakes_q;
    remaining_d = remaining_q;
    // Only an increase in the mistake count is charged; a decrease just rebases.
    if (mistakes > mistakes_q) begin
      delta_s = 13'(mistakes - mistakes_q);
    end else begin
      delta_s = 13'd0;
    end
    dec_s = (playing_condition ? 13'd1 : 13'd0) + delta_s * 13'(PENALTY_S);

    if (start_edge_s) begin
      remaining_d = limit_for(difficulty, 11'(LIMIT_EASY_S), 11'(LIMIT_MED_S),
                              11'(LIMIT_HARD_S));
      mistakes_d  = mistakes;
      state_d     = RUN;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          mistakes_d = mistakes;
          if (dec_s == 13'd0) begin
            remaining_d = remaining_q;
          end else if (dec_s >= {2'b00, remaining_q}) begin
            remaining_d = 11'd0;
            state_d     = EXPIRED;
          end else begin
            remaining_d = remaining_q - dec_s[REM_W-1:0];
          end
        end
        EXPIRED: begin
          remaining_d = 11'd0;
        end
        default: begin
          state_d     = IDLE;
          remaining_d = 11'd0;
        end
      endcase
    end

    if ((state_d == RUN) && (remaining_d != 11'd0) && (remaining_d <= 11'(WARN_S))) begin
      warning_d = 1'b1;
    end else begin
      warning_d = 1'b0;
    end
    expired_d = (state_d == EXPIRED);
  end

  sec_to_min_sec u_split (
    .total_i   (remaining_d),
    .minutes_o (minutes_d),
    .seconds_o (seconds_d)
  );

  // State and registered outputs, asynchronously cleared by reset.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      mistakes_q  <= 4'd0;
      remaining_q <= 11'd0;
      minutes_q   <= 5'd0;
      seconds_q   <= 6'd0;
      warning_q   <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      mistakes_q  <= mistakes_d;
      remaining_q <= remaining_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      warning_q   <= warning_d;
      expired_q   <= expired_d;
    end
  end

  assign remaining = remaining_q;
  assign minutes   = minutes_q;
  assign seconds   = seconds_q;
  assign warning   = warning_q;
  assign expired   = expired_q;

endmodule
